spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
Shares one spi_master between NUM_REQ requesters using round-robin arbitration. It accepts single-word requests and sequences the master's host-side start/data_in/done handshake. It returns each received word to the requester that issued it. It also drives a one-hot slave-select vector so that external logic can steer the master's spi_cs_n to the granted requester's slave.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_LENGTH, 8, SPI word width; must equal the spi_master DATA_LENGTH
ID_W, $clog2(NUM_REQ), requester index width (localparam, minimum 1)

Ports:
clk  in  1  system clock, the same clock as spi_master
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request level; held until the matching ack
req_wdata  in  NUM_REQ*DATA_LENGTH  word to transmit; slice i belongs to requester i; held until ack
ack  out  NUM_REQ  one-cycle pulse: request accepted, so req and wdata may drop
rvalid  out  NUM_REQ  one-cycle pulse: rdata is valid for that requester
rdata  out  DATA_LENGTH  received MISO word; held until the next capture
sel  out  NUM_REQ  one-hot slave select, high for the whole transaction
m_start  out  1  to spi_master start
m_data_in  out  DATA_LENGTH  to spi_master data_in
m_busy  in  1  from spi_master busy
m_done  in  1  from spi_master done
m_data_out  in  DATA_LENGTH  from spi_master data_out
busy  out  1  high when the arbiter state is not ARB_IDLE
cur_id  out  ID_W  index of the granted requester; valid while busy
txn_count  out  16  count of completed transactions; wraps from 0xFFFF to 0

Behaviour:
- Reset: state ARB_IDLE. All outputs are 0: ack, rvalid, rdata, sel, m_start, m_data_in, busy, cur_id, txn_count. The round-robin pointer resets to NUM_REQ-1, which makes requester 0 the highest priority first.
- Reset asserted mid-transaction aborts immediately. sel drops, which deasserts the external chip select. The arbiter does not wait for the master.
- Every output is registered.
- FSM states: ARB_IDLE -> ARB_LAUNCH -> ARB_WAIT -> ARB_IDLE.
- ARB_IDLE, cycle T, with any req bit set:
  - The winner w is the first set bit searching from (ptr+1) mod NUM_REQ upward, with wrap-around.
  - Latch w and req_wdata[w]; go to ARB_LAUNCH.
  - Nothing happens if req is all zeros.
- ARB_LAUNCH, cycle T+1:
  - ack[w]=1, m_start=1, m_data_in=latched word, sel=onehot(w), busy=1, cur_id=w.
  - Next state is ARB_WAIT.
- ARB_WAIT:
  - m_start=0.
  - m_data_in and sel are held.
  - Wait for m_done==1.
  - On the cycle D where m_done==1: rdata<=m_data_out, rvalid[w]<=1 (visible at D+1), ptr<=w, txn_count<=txn_count+1, and go to ARB_IDLE.
  - At D+1: sel=0, busy=0, and m_data_in is held.
  - m_data_out is captured only on the m_done cycle, because the master clears it on the next cycle.
- Throughput: a new grant is evaluated at D+1 and launched at D+2. The master is back in IDLE by then.
- Request handling rules:
  - The latency from req to m_start is 2 cycles.
  - Only one transaction is in flight at a time.
  - A req arriving during ARB_LAUNCH or ARB_WAIT waits.
  - A req still high after its ack is treated as a new request. It is subject to round-robin, so it loses to other pending requesters.
  - A req that drops before ack is simply not served. This is legal.
- Simultaneous events: the rvalid pulse to one requester can coincide with a new arbitration. These are independent.
- Exactly one ack and exactly one rvalid occur per transaction, both to the same index.
- Assertions:
  - m_start is never high while m_busy is high.
  - sel is one-hot or zero.
  - m_done seen outside ARB_WAIT is flagged by an assertion and ignored.

Decomposition:
- Package spi_ctrl_pkg holds arb_state_t (enum ARB_IDLE, ARB_LAUNCH, ARB_WAIT). Its names must not collide with the spi_master state_t.
- Sub-module spi_rr_picker(NUM_REQ): combinational first-set-bit search from ptr+1 with wrap-around. Outputs are grant_valid and grant_id.

Test Plan:
1. Single request, NUM_REQ=4:
   - Stimulus: req=0001, wdata0=0xA5; slave model returns 0x3C.
   - Required: ack[0] at T+1, m_start one pulse with m_data_in=0xA5, sel=0001 until D, rvalid[0] with rdata=0x3C, txn_count=1.
2. All four requesters held high from reset, with wdata=0x10..0x13:
   - Required: grant order 0,1,2,3,0.
   - Each rdata is returned to the matching rvalid index.
3. Requester 2 keeps req high after ack while requester 1 also requests:
   - Required: next grant is 3 if pending, otherwise 1, before 2 is granted again.
4. Back-to-back transactions:
   - Required: the next m_start occurs exactly 2 cycles after m_done.
   - m_start never overlaps m_busy.
   - sel drops for at least 1 cycle between transactions.
5. rst_n asserted during ARB_WAIT:
   - Required: all outputs 0 asynchronously.
   - After release, req=0100 is granted to requester 2 with correct data.
6. txn_count preloaded via force at 0xFFFF, then one transaction:
   - Required: txn_count wraps to 0x0000.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI transaction arbiter.
// The arbiter state names are prefixed ARB_ so they stay distinct from the spi_master states.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAUNCH = 2'd1,
    ARB_WAIT   = 2'd2
  } arb_state_t;

  localparam int TXN_CNT_W = 16;

endpackage

// File: rtl/spi_rr_picker.sv
// Round-robin winner search: the first set request bit after ptr, wrapping around.
module spi_rr_picker #(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id
);

  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    // The last granted index (ptr) is checked last, so it has the lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master among NUM_REQ requesters. It runs one single-word transaction at a time
// and returns each received word to the requester that issued it.
module spi_txn_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  DATA_LENGTH = 8,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [DATA_LENGTH-1:0]         rdata,
  output logic [NUM_REQ-1:0]             sel,
  output logic                           m_start,
  output logic [DATA_LENGTH-1:0]         m_data_in,
  input  logic                           m_busy,
  input  logic                           m_done,
  input  logic [DATA_LENGTH-1:0]         m_data_out,
  output logic                           busy,
  output logic [ID_W-1:0]                cur_id,
  output logic [TXN_CNT_W-1:0]           txn_count
);

  arb_state_t                 state_q, state_d;
  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic [ID_W-1:0]            cur_id_q, cur_id_d;
  logic [NUM_REQ-1:0]         ack_q, ack_d;
  logic [NUM_REQ-1:0]         rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]         sel_q, sel_d;
  logic [DATA_LENGTH-1:0]     rdata_q, rdata_d;
  logic [DATA_LENGTH-1:0]     m_data_in_q, m_data_in_d;
  logic                       m_start_q, m_start_d;
  logic                       busy_q, busy_d;
  logic [TXN_CNT_W-1:0]       txn_count_q, txn_count_d;
  logic                       grant_valid;
  logic [ID_W-1:0]            grant_id;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req         (req),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_id_d    = cur_id_q;
    ack_d       = '0;
    rvalid_d    = '0;
    sel_d       = sel_q;
    rdata_d     = rdata_q;
    m_data_in_d = m_data_in_q;
    m_start_d   = 1'b0;
    busy_d      = busy_q;
    txn_count_d = txn_count_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d     = ARB_LAUNCH;
          cur_id_d    = grant_id;
          ack_d       = onehot(grant_id);
          sel_d       = onehot(grant_id);
          m_start_d   = 1'b1;
          m_data_in_d = req_wdata[grant_id*DATA_LENGTH +: DATA_LENGTH];
          busy_d      = 1'b1;
        end
      end
      ARB_LAUNCH: state_d = ARB_WAIT;
      ARB_WAIT: begin
        // The master clears data_out after done, so capture it on this cycle only.
        if (m_done) begin
          state_d     = ARB_IDLE;
          rdata_d     = m_data_out;
          rvalid_d    = onehot(cur_id_q);
          ptr_d       = cur_id_q;
          txn_count_d = txn_count_q + 1'b1;
          sel_d       = '0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      cur_id_q    <= '0;
      ack_q       <= '0;
      rvalid_q    <= '0;
      sel_q       <= '0;
      rdata_q     <= '0;
      m_data_in_q <= '0;
      m_start_q   <= 1'b0;
      busy_q      <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      sel_q       <= sel_d;
      rdata_q     <= rdata_d;
      m_data_in_q <= m_data_in_d;
      m_start_q   <= m_start_d;
      busy_q      <= busy_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign ack       = ack_q;
  assign rvalid    = rvalid_q;
  assign sel       = sel_q;
  assign rdata     = rdata_q;
  assign m_data_in = m_data_in_q;
  assign m_start   = m_start_q;
  assign busy      = busy_q;
  assign cur_id    = cur_id_q;
  assign txn_count = txn_count_q;

  a_start_not_busy: assert property (@(posedge clk) disable iff (!rst_n) !(m_start_q && m_busy));
  a_sel_onehot0:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel_q));
  a_done_in_wait:   assert property (@(posedge clk) disable iff (!rst_n) m_done |-> (state_q == ARB_WAIT));

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter, paired with a simple behavioural spi_master and slave.
module tb_spi_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_wdata;
  logic [3:0]  ack, rvalid, sel;
  logic [7:0]  rdata, m_data_in, m_data_out;
  logic        m_start, m_busy, m_done, busy;
  logic [1:0]  cur_id;
  logic [15:0] txn_count;

  spi_txn_arbiter #(.NUM_REQ(4), .DATA_LENGTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wdata(req_wdata),
    .ack(ack), .rvalid(rvalid), .rdata(rdata), .sel(sel),
    .m_start(m_start), .m_data_in(m_data_in), .m_busy(m_busy),
    .m_done(m_done), .m_data_out(m_data_out),
    .busy(busy), .cur_id(cur_id), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] wd;
    logic [7:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_txn  = '0;

  function automatic logic [7:0] slave_resp(input logic [7:0] d);
    return d ^ 8'h99;
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  // Behavioural spi_master: busy the cycle after start, done pulse with data_out for one cycle.
  logic [2:0] mdl_cnt;
  logic [7:0] mdl_word;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_data_out <= '0; mdl_cnt <= '0; mdl_word <= '0;
    end else begin
      m_done     <= 1'b0;
      m_data_out <= '0;
      if (!m_busy && m_start) begin
        m_busy   <= 1'b1;
        mdl_cnt  <= 3'd2 + {1'b0, m_data_in[1:0]};
        mdl_word <= m_data_in;
      end else if (m_busy) begin
        if (mdl_cnt == 0) begin
          m_busy     <= 1'b0;
          m_done     <= 1'b1;
          m_data_out <= slave_resp(mdl_word);
        end else begin
          mdl_cnt <= mdl_cnt - 3'd1;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] wd, input logic [7:0] rd);
    exp_t e;
    e.id = id; e.wd = wd; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic set_word(input int i, input logic [7:0] w);
    req_wdata[i*8 +: 8] = w;
  endtask

  task automatic monitor();
    exp_t       e;
    logic [3:0] prev_sel;
    bit         want_start;
    prev_sel   = '0;
    want_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sel   = '0;
        want_start = 1'b0;
        continue;
      end
      if (want_start) begin
        check_val("b2b_start", {31'd0, m_start}, 32'd1);
        want_start = 1'b0;
      end
      if (m_start) begin
        check_val("start_vs_busy", {31'd0, m_busy}, 32'd0);
        check_val("sel_gap", {28'd0, prev_sel}, 32'd0);
        if (exp_q.size() == 0) begin
          check_val("unexpected_start", 32'd1, 32'd0);
        end else begin
          e = exp_q[0];
          check_val("ack_idx",   {28'd0, ack}, {28'd0, oh(e.id)});
          check_val("sel_start", {28'd0, sel}, {28'd0, oh(e.id)});
          check_val("cur_id",    {30'd0, cur_id}, {30'd0, e.id});
          check_val("m_data_in", {24'd0, m_data_in}, {24'd0, e.wd});
          check_val("busy_start", {31'd0, busy}, 32'd1);
        end
      end
      if (m_done && exp_q.size() != 0) begin
        e = exp_q[0];
        check_val("sel_at_done", {28'd0, sel}, {28'd0, oh(e.id)});
      end
      if (rvalid != 0) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_rvalid", {28'd0, rvalid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("rvalid_idx", {28'd0, rvalid}, {28'd0, oh(e.id)});
          check_val("rdata", {24'd0, rdata}, {24'd0, e.rd});
          check_val("sel_after", {28'd0, sel}, 32'd0);
          check_val("busy_after", {31'd0, busy}, 32'd0);
          exp_txn = exp_txn + 16'd1;
          check_val("txn_count", {16'd0, txn_count}, {16'd0, exp_txn});
          if (req != 0) want_start = 1'b1;
        end
      end
      prev_sel = sel;
    end
  endtask

  task automatic wait_ack(input int i, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (ack[i]) seen = 1'b1;
    end
    if (!seen) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check_val(tag, exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_ack"},       {28'd0, ack}, 32'd0);
    check_val({pfx, "_rvalid"},    {28'd0, rvalid}, 32'd0);
    check_val({pfx, "_rdata"},     {24'd0, rdata}, 32'd0);
    check_val({pfx, "_sel"},       {28'd0, sel}, 32'd0);
    check_val({pfx, "_m_start"},   {31'd0, m_start}, 32'd0);
    check_val({pfx, "_m_data_in"}, {24'd0, m_data_in}, 32'd0);
    check_val({pfx, "_busy"},      {31'd0, busy}, 32'd0);
    check_val({pfx, "_cur_id"},    {30'd0, cur_id}, 32'd0);
    check_val({pfx, "_txn_count"}, {16'd0, txn_count}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = '0; req_wdata = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, fixed slave reply 0x3C.
    set_word(0, 8'hA5);
    push_exp(2'd0, 8'hA5, 8'h3C);
    @(posedge clk); #1 req = 4'b0001;
    @(negedge clk); check_val("t1_ack_early", {28'd0, ack}, 32'd0);
    @(negedge clk); check_val("t1_ack_lat", {28'd0, ack}, 32'd1);
    req = '0;
    wait_drain("t1_timeout");
    check_val("t1_count", {16'd0, txn_count}, 32'd1);

    // All four requesting from reset: 0,1,2,3,0.
    @(negedge clk); rst_n = 1'b0; exp_txn = '0;
    for (int i = 0; i < 4; i++) set_word(i, 8'h10 + 8'(i));
    req = 4'hF;
    for (int k = 0; k < 5; k++) push_exp(2'(k % 4), 8'h10 + 8'(k % 4), slave_resp(8'h10 + 8'(k % 4)));
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 400 && n < 5; c++) begin
      @(negedge clk);
      if (ack != 0) n++;
    end
    if (n < 5) check_val("t2_ack_timeout", n, 32'd5);
    req = '0;
    wait_drain("t2_timeout");

    // Requester 2 holds req after ack; 1 joins -> 2,1,2.
    set_word(1, 8'h21); set_word(2, 8'h22); set_word(3, 8'h23);
    push_exp(2'd2, 8'h22, slave_resp(8'h22));
    push_exp(2'd1, 8'h21, slave_resp(8'h21));
    push_exp(2'd2, 8'h22, slave_resp(8'h22));
    req[2] = 1'b1;
    wait_ack(2, "t3a_ack2"); req[1] = 1'b1;
    wait_ack(1, "t3a_ack1"); req[1] = 1'b0;
    wait_ack(2, "t3a_ack2b"); req[2] = 1'b0;
    wait_drain("t3a_timeout");

    // Same with 3 pending as well -> 2,3,1,2.
    push_exp(2'd2, 8'h22, slave_resp(8'h22));
    push_exp(2'd3, 8'h23, slave_resp(8'h23));
    push_exp(2'd1, 8'h21, slave_resp(8'h21));
    push_exp(2'd2, 8'h22, slave_resp(8'h22));
    req[2] = 1'b1;
    wait_ack(2, "t3b_ack2"); req[3] = 1'b1; req[1] = 1'b1;
    wait_ack(3, "t3b_ack3"); req[3] = 1'b0;
    wait_ack(1, "t3b_ack1"); req[1] = 1'b0;
    wait_ack(2, "t3b_ack2b"); req[2] = 1'b0;
    wait_drain("t3b_timeout");

    // Reset while the master is mid-transfer.
    set_word(0, 8'h55);
    push_exp(2'd0, 8'h55, slave_resp(8'h55));
    req = 4'b0001;
    wait_ack(0, "t5_ack0"); req = '0;
    n = 0;
    for (int c = 0; c < 50 && n == 0; c++) begin
      @(negedge clk);
      if (m_busy) n = 1;
    end
    check_val("t5_master_busy", n, 32'd1);
    check_val("t5_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t5");
    exp_q.delete(); exp_txn = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    set_word(2, 8'h77);
    push_exp(2'd2, 8'h77, slave_resp(8'h77));
    req = 4'b0100;
    wait_ack(2, "t5_ack2"); req = '0;
    wait_drain("t5_timeout");

    // Counter wrap from 0xFFFF.
    force dut.txn_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.txn_count_q;
    exp_txn = 16'hFFFF;
    @(negedge clk);
    check_val("t6_preset", {16'd0, txn_count}, 32'hFFFF);
    set_word(1, 8'h5A);
    push_exp(2'd1, 8'h5A, slave_resp(8'h5A));
    req = 4'b0010;
    wait_ack(1, "t6_ack1"); req = '0;
    wait_drain("t6_timeout");
    check_val("t6_wrap", {16'd0, txn_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
